// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI receive peripheral:
// AHB transfer codes, register offsets and the receiver state encoding.
package spi_pkg;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    // Word offsets, i.e. haddr[4:2]
    localparam logic [2:0] REG_RX_DATA  = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_NUM_BITS = 3'd2;
    localparam logic [2:0] REG_CTRL     = 3'd3;

    typedef enum logic {
        RX_IDLE,
        RX_SHIFT
    } spi_rx_state_t;

    // Keeps the low nbits+1 bits of a shifted word (nbits = 0..31).
    function automatic logic [31:0] word_mask(input logic [4:0] nbits);
        word_mask = 32'hFFFF_FFFF >> (5'd31 - nbits);
    endfunction

endpackage

// File: rtl/spi_rx_io_sync_fifo.sv
// Single-clock FIFO with flush; the head entry is visible without popping.
// Pointers wrap naturally, occupancy is tracked by a separate counter.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_rx_io.sv
// AHB-lite SPI slave receiver (mode 0): synchronizes the pins, deserializes
// MSB-first words of programmable length and queues them with their dc flag.
module spi_rx_io
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ahb_s0_haddr_i,
    input  logic        ahb_s0_hwrite_i,
    input  logic [2:0]  ahb_s0_hsize_i,
    input  logic [2:0]  ahb_s0_hburst_i,
    input  logic [3:0]  ahb_s0_hprot_i,
    input  logic [1:0]  ahb_s0_htrans_i,
    input  logic        ahb_s0_hmastlock_i,
    input  logic [31:0] ahb_s0_hwdata_i,
    output logic        ahb_s0_hready_o,
    output logic        ahb_s0_hresp_o,
    output logic [31:0] ahb_s0_hrdata_o,
    input  logic        spi_sclk_i,
    input  logic        spi_sdi_i,
    input  logic        csn_i,
    input  logic        dc_i,
    output logic        rx_irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [SYNC_STAGES-1:0] sclk_sync, sdi_sync, csn_sync, dc_sync;
    logic                   sclk_hist, csn_hist;
    logic                   sclk_s, sdi_s, csn_s, dc_s;
    logic                   sclk_rise, csn_fall, csn_rise;

    logic [2:0]  addr_q;
    logic        wr_pend, rd_pend;
    logic [4:0]  num_bits;
    logic        enable, irq_en, overflow, frame_err, flush_q;
    logic        wr_ctrl, clr_err, fifo_pop, overflow_evt;

    spi_rx_state_t state;
    logic [4:0]    bit_cnt, cur_bits;
    logic [31:0]   shift_reg, next_shift;
    logic          push_q, frame_err_evt;
    logic [32:0]   push_data_q;

    logic [32:0]   head_data;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    logic unused_bits;
    assign unused_bits = ^{ahb_s0_hsize_i, ahb_s0_hburst_i, ahb_s0_hprot_i, ahb_s0_hmastlock_i,
                           ahb_s0_haddr_i[31:5], ahb_s0_haddr_i[1:0], ahb_s0_htrans_i[0]};

    assign ahb_s0_hready_o = 1'b1;
    assign ahb_s0_hresp_o  = 1'b0;

    // Pin synchronizers reset to the idle bus levels so no false edge appears after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= '0;
            sdi_sync  <= '0;
            csn_sync  <= '1;
            dc_sync   <= '0;
            sclk_hist <= 1'b0;
            csn_hist  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi_i};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn_i};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc_i};
            sclk_hist <= sclk_s;
            csn_hist  <= csn_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign dc_s      = dc_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s && !sclk_hist;
    assign csn_fall  = !csn_s && csn_hist;
    assign csn_rise  = csn_s && !csn_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wr_pend <= 1'b0;
            rd_pend <= 1'b0;
        end else if (ahb_s0_htrans_i[1]) begin
            addr_q  <= ahb_s0_haddr_i[4:2];
            wr_pend <= ahb_s0_hwrite_i;
            rd_pend <= !ahb_s0_hwrite_i;
        end else begin
            wr_pend <= 1'b0;
            rd_pend <= 1'b0;
        end
    end

    assign wr_ctrl      = wr_pend && (addr_q == REG_CTRL);
    assign clr_err      = wr_ctrl && ahb_s0_hwdata_i[3];
    assign fifo_pop     = rd_pend && (addr_q == REG_RX_DATA);
    assign overflow_evt = push_q && fifo_full && !fifo_pop && !flush_q;

    // Error events take priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_bits  <= '0;
            enable    <= 1'b0;
            irq_en    <= 1'b0;
            flush_q   <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            flush_q <= wr_ctrl && ahb_s0_hwdata_i[2];
            if (wr_pend && (addr_q == REG_NUM_BITS)) begin
                num_bits <= ahb_s0_hwdata_i[4:0];
            end
            if (wr_ctrl) begin
                enable <= ahb_s0_hwdata_i[0];
                irq_en <= ahb_s0_hwdata_i[1];
            end
            if (overflow_evt) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (frame_err_evt) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

    assign next_shift = {shift_reg[30:0], sdi_s};

    // cur_bits holds the length of the word in flight, so NUM_BITS edits only apply at reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RX_IDLE;
            bit_cnt       <= '0;
            cur_bits      <= '0;
            shift_reg     <= '0;
            push_q        <= 1'b0;
            push_data_q   <= '0;
            frame_err_evt <= 1'b0;
        end else begin
            push_q        <= 1'b0;
            frame_err_evt <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (enable && csn_fall) begin
                        state     <= RX_SHIFT;
                        bit_cnt   <= num_bits;
                        cur_bits  <= num_bits;
                        shift_reg <= '0;
                    end
                end
                RX_SHIFT: begin
                    if (!enable) begin
                        state <= RX_IDLE;
                    end else if (csn_rise) begin
                        state         <= RX_IDLE;
                        frame_err_evt <= (bit_cnt != cur_bits);
                    end else if (sclk_rise) begin
                        shift_reg <= next_shift;
                        if (bit_cnt == '0) begin
                            push_q      <= 1'b1;
                            push_data_q <= {dc_s, next_shift & word_mask(cur_bits)};
                            bit_cnt     <= num_bits;
                            cur_bits    <= num_bits;
                        end else begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (fifo_pop),
        .flush     (flush_q),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        ahb_s0_hrdata_o = '0;
        if (rd_pend) begin
            case (addr_q)
                REG_RX_DATA:  ahb_s0_hrdata_o = fifo_empty ? 32'd0 : head_data[31:0];
                REG_STATUS:   ahb_s0_hrdata_o = {16'd0, 8'(fifo_count), 2'b00,
                                                 (state != RX_IDLE), head_data[32] && !fifo_empty,
                                                 frame_err, overflow, fifo_full, !fifo_empty};
                REG_NUM_BITS: ahb_s0_hrdata_o = {27'd0, num_bits};
                REG_CTRL:     ahb_s0_hrdata_o = {30'd0, irq_en, enable};
                default:      ahb_s0_hrdata_o = '0;
            endcase
        end
    end

    assign rx_irq_o = irq_en && !fifo_empty;

endmodule

// File: tb/tb_spi_rx_io.sv
// Self-checking bench for spi_rx_io: drives SPI pins and AHB accesses and
// compares every register read with a queue-based model of the receiver.
module tb_spi_rx_io;
    import spi_pkg::*;

    localparam int DEPTH = 8;
    localparam int HALF  = 6;
    localparam logic [31:0] BASE = 32'hC000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hwrite, hready, hresp;
    logic [1:0]  htrans;
    logic        sclk, sdi, csn, dc, rx_irq;

    typedef struct {
        bit        dc;
        bit [31:0] w;
    } entry_t;

    entry_t q[$];
    bit     m_ovf, m_ferr, m_irqen;
    int     checks = 0;
    int     fails  = 0;

    always #5 clk = ~clk;

    spi_rx_io #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .ahb_s0_haddr_i     (haddr),
        .ahb_s0_hwrite_i    (hwrite),
        .ahb_s0_hsize_i     (3'b010),
        .ahb_s0_hburst_i    (3'b000),
        .ahb_s0_hprot_i     (4'b0011),
        .ahb_s0_htrans_i    (htrans),
        .ahb_s0_hmastlock_i (1'b0),
        .ahb_s0_hwdata_i    (hwdata),
        .ahb_s0_hready_o    (hready),
        .ahb_s0_hresp_o     (hresp),
        .ahb_s0_hrdata_o    (hrdata),
        .spi_sclk_i         (sclk),
        .spi_sdi_i          (sdi),
        .csn_i              (csn),
        .dc_i               (dc),
        .rx_irq_o           (rx_irq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ahbWrite(input logic [2:0] reg_idx, input logic [31:0] data);
        haddr  = BASE | {27'd0, reg_idx, 2'b00};
        hwrite = 1'b1;
        htrans = HTRANS_NSEQ;
        waitClk(1);
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hwdata = data;
        waitClk(1);
    endtask

    task automatic ahbRead(input logic [2:0] reg_idx, output logic [31:0] data);
        haddr  = BASE | {27'd0, reg_idx, 2'b00};
        hwrite = 1'b0;
        htrans = HTRANS_NSEQ;
        waitClk(1);
        htrans = HTRANS_IDLE;
        data   = hrdata;
        waitClk(1);
    endtask

    function automatic bit [31:0] maskOf(input int nb);
        longint unsigned m;
        m = (64'd1 << (nb + 1)) - 64'd1;
        return m[31:0];
    endfunction

    function automatic void modelPush(input bit d, input bit [31:0] w);
        entry_t e;
        e.dc = d;
        e.w  = w;
        if (q.size() >= DEPTH) m_ovf = 1'b1;
        else q.push_back(e);
    endfunction

    function automatic logic [31:0] expStatus(input bit busy);
        logic [31:0] s;
        s       = '0;
        s[0]    = (q.size() != 0);
        s[1]    = (q.size() == DEPTH);
        s[2]    = m_ovf;
        s[3]    = m_ferr;
        s[4]    = (q.size() != 0) ? q[0].dc : 1'b0;
        s[5]    = busy;
        s[15:8] = 8'(q.size());
        return s;
    endfunction

    task automatic checkStatus(input string tag, input bit busy);
        logic [31:0] rd;
        ahbRead(REG_STATUS, rd);
        checkOutput(tag, rd, expStatus(busy));
        checkOutput({tag, "_irq"}, {31'd0, rx_irq}, {31'd0, m_irqen && (q.size() != 0)});
    endtask

    task automatic readData(input string tag);
        logic [31:0] rd, exp;
        ahbRead(REG_RX_DATA, rd);
        exp = '0;
        if (q.size() != 0) exp = q.pop_front().w;
        checkOutput(tag, rd, exp);
    endtask

    task automatic sendBit(input bit b);
        sdi = b;
        waitClk(HALF);
        sclk = 1'b1;
        waitClk(HALF);
        sclk = 1'b0;
    endtask

    task automatic applyStimulus(input bit [31:0] w, input int nb, input bit d);
        dc = d;
        for (int i = nb; i >= 0; i--) sendBit(w[i]);
        modelPush(d, w & maskOf(nb));
    endtask

    task automatic csnLow();
        csn = 1'b0;
        waitClk(HALF);
    endtask

    task automatic csnHigh();
        waitClk(2);
        csn = 1'b1;
        waitClk(HALF + 4);
    endtask

    task automatic configure(input int nb, input bit irq);
        ahbWrite(REG_NUM_BITS, 32'(nb));
        ahbWrite(REG_CTRL, {30'd0, irq, 1'b1});
        m_irqen = irq;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd, exp;
        bit [31:0]   w4;
        reset  = 1'b1;
        haddr  = '0;
        hwdata = '0;
        hwrite = 1'b0;
        htrans = HTRANS_IDLE;
        sclk   = 1'b0;
        sdi    = 1'b0;
        csn    = 1'b1;
        dc     = 1'b0;
        m_ovf  = 0;
        m_ferr = 0;
        m_irqen = 0;
        waitClk(3);
        reset = 1'b0;
        waitClk(1);

        checkOutput("reset_hready", {31'd0, hready}, 32'd1);
        checkOutput("reset_hresp", {31'd0, hresp}, 32'd0);
        checkOutput("reset_hrdata", hrdata, 32'd0);
        checkStatus("reset_status", 1'b0);
        ahbRead(REG_CTRL, rd);
        checkOutput("reset_ctrl", rd, 32'd0);
        readData("reset_rx_empty");

        // Single byte with dc=1
        configure(7, 1'b0);
        csnLow();
        applyStimulus(32'hA5, 7, 1'b1);
        csnHigh();
        ahbRead(REG_STATUS, rd);
        checkOutput("t1_status", rd, 32'h0000_0111);
        readData("t1_data");
        checkStatus("t1_status_after", 1'b0);

        // Two 32-bit words in one frame, busy while csn low, irq enabled
        configure(31, 1'b1);
        csnLow();
        applyStimulus(32'hDEADBEEF, 31, 1'b0);
        waitClk(4);
        checkStatus("t2_busy_mid", 1'b1);
        applyStimulus(32'h12345678, 31, 1'b1);
        csnHigh();
        checkStatus("t2_idle", 1'b0);
        readData("t2_word0");
        readData("t2_word1");
        checkStatus("t2_drained", 1'b0);

        // Overflow with nine bytes into a depth-8 FIFO
        configure(7, 1'b0);
        csnLow();
        for (int i = 0; i < 9; i++) applyStimulus(32'(i), 7, 1'b0);
        csnHigh();
        checkStatus("t3_full_ovf", 1'b0);
        for (int i = 0; i < 8; i++) readData($sformatf("t3_byte%0d", i));
        ahbWrite(REG_CTRL, 32'h9);
        m_ovf = 0;
        checkStatus("t3_clr_err", 1'b0);

        // Partial word raises frame_err
        csnLow();
        dc = 1'b0;
        for (int i = 0; i < 5; i++) sendBit(i[0]);
        csnHigh();
        m_ferr = 1;
        checkStatus("t4_frame_err", 1'b0);
        ahbWrite(REG_CTRL, 32'h9);
        m_ferr = 0;
        checkStatus("t4_clr_err", 1'b0);

        // RX_DATA pop lands in the push cycle of the fourth word
        csnLow();
        applyStimulus(32'h11, 7, 1'b0);
        applyStimulus(32'h22, 7, 1'b1);
        applyStimulus(32'h33, 7, 1'b0);
        w4 = 32'h4C;
        dc = 1'b1;
        for (int i = 7; i >= 1; i--) sendBit(w4[i]);
        sdi = w4[0];
        waitClk(HALF);
        sclk = 1'b1;
        waitClk(2);
        ahbRead(REG_RX_DATA, rd);
        exp = q.pop_front().w;
        modelPush(1'b1, w4);
        checkOutput("t5_pop_on_push", rd, exp);
        waitClk(HALF);
        sclk = 1'b0;
        csnHigh();
        checkStatus("t5_count3", 1'b0);
        readData("t5_order");
        ahbWrite(REG_CTRL, 32'h5);
        q.delete();
        checkStatus("t5_flush", 1'b0);

        // Reset in the middle of a frame
        csnLow();
        for (int i = 0; i < 4; i++) sendBit(1'b1);
        reset = 1'b1;
        csn   = 1'b1;
        waitClk(2);
        reset = 1'b0;
        q.delete();
        m_ovf = 0;
        m_ferr = 0;
        m_irqen = 0;
        waitClk(2);
        checkStatus("t6_reset_status", 1'b0);
        ahbRead(REG_NUM_BITS, rd);
        checkOutput("t6_reset_numbits", rd, 32'd0);
        ahbRead(REG_CTRL, rd);
        checkOutput("t6_reset_ctrl", rd, 32'd0);
        configure(7, 1'b1);
        csnLow();
        applyStimulus(32'h3C, 7, 1'b0);
        csnHigh();
        checkStatus("t6_after_status", 1'b0);
        readData("t6_after_data");

        // Randomized frames of random word length
        for (int it = 0; it < 6; it++) begin
            int nb, nw;
            nb = $urandom_range(0, 15);
            nw = $urandom_range(1, 3);
            configure(nb, it[0]);
            csnLow();
            for (int k = 0; k < nw; k++) applyStimulus($urandom, nb, 1'($urandom_range(0, 1)));
            csnHigh();
            checkStatus($sformatf("rnd%0d_status", it), 1'b0);
            for (int k = 0; k < nw; k++) readData($sformatf("rnd%0d_word%0d", it, k));
            checkStatus($sformatf("rnd%0d_empty", it), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
